// File: rtl/fp16_norm_round_if.sv
// Handshake and data bundle between the FP16 adder, the normalise/round stage
// and its downstream consumer.
interface fp16_norm_round_if #(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10
);
  logic                  in_valid;
  logic                  in_ready;
  logic [EXP_W-1:0]      in_exp;
  logic [FRAC_W+3:0]     in_sig;
  logic                  in_sticky;
  logic                  out_valid;
  logic                  out_ready;
  logic [EXP_W+FRAC_W:0] out_data;
  logic                  out_ovf;
  logic                  out_zero;

  modport master (
    output in_valid, in_exp, in_sig, in_sticky, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_exp, in_sig, in_sticky, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_zero
  );
endinterface

// File: rtl/fp16_norm_round.sv
// Normalise-and-round stage for the positive FP16 adder: shifts the raw
// significand into normal form, rounds to nearest-even and packs the result.
module fp16_norm_round #(
  parameter int EXP_W   = 5,
  parameter int FRAC_W  = 10,
  parameter int MAX_EXP = 31
) (
  input  logic                clk,
  input  logic                rst_n,
  fp16_norm_round_if.slave    bus
);
  localparam int SIG_W = FRAC_W + 4;
  localparam int E_W   = EXP_W + 1;
  localparam int W_W   = EXP_W + FRAC_W + 1;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t           state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [E_W-1:0]   e_q, e_d;
  logic             sticky_q, sticky_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [W_W-1:0]   out_data_q, out_data_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_zero_q, out_zero_d;

  logic             round_up;
  logic [SIG_W-1:0] sig_rnd;
  logic [E_W-1:0]   e_rnd;
  logic [EXP_W-1:0] exp_field;
  logic [W_W-1:0]   res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sig_q      <= '0;
      e_q        <= '0;
      sticky_q   <= 1'b0;
      ovf_pend_q <= 1'b0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
      out_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sig_q      <= sig_d;
      e_q        <= e_d;
      sticky_q   <= sticky_d;
      ovf_pend_q <= ovf_pend_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
      out_zero_q <= out_zero_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sig_d      = sig_q;
    e_d        = e_q;
    sticky_d   = sticky_q;
    ovf_pend_d = ovf_pend_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;
    out_zero_d = out_zero_q;
    round_up   = 1'b0;
    sig_rnd    = sig_q;
    e_rnd      = e_q;
    exp_field  = '0;
    res        = '0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sig_d      = bus.in_sig;
          sticky_d   = bus.in_sticky;
          // A zero exponent field shares the scale of exponent 1 (subnormal range).
          e_d        = (bus.in_exp == '0) ? E_W'(1) : {1'b0, bus.in_exp};
          ovf_pend_d = (bus.in_exp == EXP_W'(MAX_EXP));
          state_d    = NORM;
        end
      end

      NORM: begin
        if (sig_q[SIG_W-1]) begin
          sig_d    = sig_q >> 1;
          sticky_d = sticky_q | sig_q[0];
          e_d      = e_q + 1'b1;
          state_d  = ROUND;
        end else if (sig_q[SIG_W-2] || (e_q == E_W'(1)) || (sig_q == '0)) begin
          state_d = ROUND;
        end else begin
          sig_d = sig_q << 1;
          e_d   = e_q - 1'b1;
        end
      end

      ROUND: begin
        round_up = sig_q[1] & (sig_q[0] | sticky_q | sig_q[2]);
        sig_rnd  = sig_q + (round_up ? SIG_W'(4) : SIG_W'(0));
        if (sig_rnd[SIG_W-1]) begin
          sig_rnd = sig_rnd >> 1;
          e_rnd   = e_q + 1'b1;
        end
        // Hidden bit decides normal vs subnormal, including a subnormal rounded up.
        exp_field = sig_rnd[SIG_W-2] ? e_rnd[EXP_W-1:0] : '0;
        if ((e_rnd >= E_W'(MAX_EXP)) || ovf_pend_q) begin
          res       = {1'b0, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          out_ovf_d = 1'b1;
        end else begin
          res       = {1'b0, exp_field, sig_rnd[SIG_W-3:2]};
          out_ovf_d = 1'b0;
        end
        sig_d      = sig_rnd;
        e_d        = e_rnd;
        out_data_d = res;
        out_zero_d = (res == '0);
        state_d    = DONE;
      end

      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_zero  = out_zero_q;
endmodule

// File: tb/tb_fp16_norm_round.sv
// Directed bench for fp16_norm_round: hand-computed vectors, latency,
// backpressure and mid-operation reset.
module tb_fp16_norm_round;
  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  fp16_norm_round_if bus ();

  fp16_norm_round dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    assert (obs === exp_v)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Runs one operation with out_ready high; checks latency, result and handoff.
  task automatic do_op(input string tag, input logic [4:0] e_in, input logic [13:0] s_in,
                       input logic st_in, input logic [15:0] exp_data, input logic exp_ovf,
                       input logic exp_zero, input int exp_lat);
    int lat;
    lat = 0;
    while (!bus.in_ready && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    bus.in_valid  = 1'b1;
    bus.in_exp    = e_in;
    bus.in_sig    = s_in;
    bus.in_sticky = st_in;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, "_lat"},  32'(lat), 32'(exp_lat));
    chk({tag, "_data"}, 32'(bus.out_data), 32'(exp_data));
    chk({tag, "_ovf"},  32'(bus.out_ovf), 32'(exp_ovf));
    chk({tag, "_zero"}, 32'(bus.out_zero), 32'(exp_zero));
    @(posedge clk); #1;
    chk({tag, "_drop"}, 32'({bus.out_valid, bus.in_ready}), 32'b01);
    $display("[TB] op %s exp=%0d sig=%h sticky=%0d -> data=%h ovf=%0d zero=%0d lat=%0d",
             tag, e_in, s_in, st_in, exp_data, exp_ovf, exp_zero, lat);
  endtask

  initial begin
    int seen;
    tests_run     = 0;
    tests_failed  = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_exp    = '0;
    bus.in_sig    = '0;
    bus.in_sticky = 1'b0;
    bus.out_ready = 1'b0;

    #12;
    chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data), 32'd0);
    chk("rst_ovf_zero",  32'({bus.out_ovf, bus.out_zero}), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("one",        5'd15, 14'h1000, 1'b0, 16'h3C00, 1'b0, 1'b0, 2);
    do_op("carry",      5'd15, 14'h2000, 1'b0, 16'h4000, 1'b0, 1'b0, 2);
    do_op("carry_ovf",  5'd30, 14'h2000, 1'b0, 16'h7C00, 1'b1, 1'b0, 2);
    do_op("in_inf",     5'd31, 14'h1000, 1'b0, 16'h7C00, 1'b1, 1'b0, 2);
    do_op("tie_even",   5'd15, 14'h1002, 1'b0, 16'h3C00, 1'b0, 1'b0, 2);
    do_op("tie_odd",    5'd15, 14'h1006, 1'b0, 16'h3C02, 1'b0, 1'b0, 2);
    do_op("sticky_up",  5'd15, 14'h1002, 1'b1, 16'h3C01, 1'b0, 1'b0, 2);
    do_op("lshift2",    5'd15, 14'h0400, 1'b0, 16'h3400, 1'b0, 1'b0, 4);
    // e=2 -> one shift to e=1, sig 0x0800 -> frac bit 9, value 2^-15.
    do_op("sub_clamp",  5'd2,  14'h0400, 1'b0, 16'h0200, 1'b0, 1'b0, 3);
    do_op("zero",       5'd15, 14'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 2);
    do_op("rnd_carry",  5'd15, 14'h1FFE, 1'b0, 16'h4000, 1'b0, 1'b0, 2);
    do_op("sub_to_nrm", 5'd1,  14'h0FFE, 1'b0, 16'h0400, 1'b0, 1'b0, 2);

    // Backpressure: result held, new input ignored.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_exp    = 5'd15;
    bus.in_sig    = 14'h1000;
    bus.in_sticky = 1'b0;
    @(posedge clk); #1;
    bus.in_exp = 5'd20;
    bus.in_sig = 14'h1004;
    repeat (2) begin @(posedge clk); #1; end
    chk("bp_valid", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_data",  32'(bus.out_data), 32'h3C00);
      chk("bp_ready", 32'({bus.out_valid, bus.in_ready}), 32'b10);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("bp_no_extra", 32'(seen), 32'd0);
    $display("[TB] op backpressure held 5 cycles data=%h", bus.out_data);

    // Reset during NORM drops the operation.
    bus.in_valid = 1'b1;
    bus.in_exp   = 5'd15;
    bus.in_sig   = 14'h0400;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("mid_busy", 32'(bus.in_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    #3 rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("mid_rst_dropped", 32'(seen), 32'd0);
    $display("[TB] op reset_in_norm dropped outputs=%0d", seen);

    do_op("after_rst",  5'd15, 14'h1000, 1'b0, 16'h3C00, 1'b0, 1'b0, 2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
